// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain stream loader.
// Holds the loader state encoding and the header pattern helpers.
package ccff_pkg;

  localparam int CCFF_HDR_W = 8;
  localparam logic [CCFF_HDR_W-1:0] CCFF_HDR_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DONE
  } ccff_state_t;

  // Header bit at position idx when shifted MSB-first
  function automatic logic hdr_bit(
    input logic [CCFF_HDR_W-1:0] hdr,
    input logic [2:0]            idx
  );
    return hdr[~idx];
  endfunction

endpackage

// File: rtl/ccff_word_piso.sv
// Parallel-in/serial-out holding register for configuration words.
// Tracks bits left in the current word and words left in the load.
module ccff_word_piso #(
  parameter int WORD_W = 8,
  parameter int WORDS  = 8,
  parameter int LAST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              ready_en,
  input  logic              shift,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              msb,
  output logic              active
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam int NW = $clog2(WORDS + 1);

  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     wcnt;
  logic [NW-1:0]     words_left;
  logic              take;

  // A word may land on the same edge the previous one shifts its last bit
  assign in_ready = ready_en
                 && (words_left != '0)
                 && ((wcnt == '0)
                  || ((wcnt == CW'(1)) && shift));
  assign take   = in_ready && in_valid;
  assign msb    = shreg[WORD_W-1];
  assign active = (wcnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      wcnt       <= '0;
      words_left <= '0;
    end else if (init) begin
      shreg      <= '0;
      wcnt       <= '0;
      words_left <= NW'(WORDS);
    end else if (take) begin
      shreg      <= in_data;
      wcnt       <= (words_left == NW'(1)) ? CW'(LAST_W)
                                           : CW'(WORD_W);
      words_left <= words_left - NW'(1);
    end else if (shift) begin
      shreg <= shreg << 1;
      wcnt  <= wcnt - CW'(1);
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// Streams a header plus configuration words into a gated flop chain
// and verifies that the header emerges at the chain tail on time.
module ccff_stream_loader
  import ccff_pkg::*;
#(
  parameter int                    CHAIN_LEN = 64,
  parameter int                    WORD_W    = 8,
  parameter logic [CCFF_HDR_W-1:0] HDR       = CCFF_HDR_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              chain_ok
);

  localparam int SW     = $clog2(CHAIN_LEN + 9);
  localparam int WORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_W = CHAIN_LEN - (WORDS - 1) * WORD_W;
  localparam logic [SW-1:0] WIN_LO = SW'(CHAIN_LEN);
  localparam logic [SW-1:0] WIN_HI = SW'(CHAIN_LEN + 7);
  localparam logic [SW-1:0] HDR_LAST = SW'(7);

  ccff_state_t state, state_nxt;

  logic [SW-1:0] s;
  logic          err;
  logic          ok;
  logic          go;
  logic          ready_en;
  logic          piso_shift;
  logic          piso_msb;
  logic          piso_active;
  logic          in_win;
  logic [2:0]    win_idx;
  logic          chk_fail;
  logic          to_done;

  assign go         = (state == IDLE) && start;
  assign piso_shift = (state == PAYLOAD) && piso_active;
  assign chain_ok   = ok;

  ccff_word_piso #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .LAST_W (LAST_W)
  ) u_piso (
    .clk      (prog_clk),
    .rst      (pReset),
    .init     (go),
    .ready_en (ready_en),
    .shift    (piso_shift),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .msb      (piso_msb),
    .active   (piso_active)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = HEADER;
      HEADER:  if (s == HDR_LAST) state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (ccff_shift_en && (s == WIN_HI))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    ready_en      = 1'b0;
    unique case (state)
      HEADER: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = hdr_bit(HDR, s[2:0]);
        ready_en      = (s == HDR_LAST);
      end
      PAYLOAD: begin
        busy          = 1'b1;
        ccff_shift_en = piso_active;
        ccff_head     = piso_active & piso_msb;
        ready_en      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Header bit h must appear at the tail exactly CHAIN_LEN shifts later
  assign in_win   = (s >= WIN_LO) && (s <= WIN_HI);
  assign win_idx  = 3'(s - WIN_LO);
  assign chk_fail = ccff_shift_en && in_win
                 && (ccff_tail != hdr_bit(HDR, win_idx));
  assign to_done  = (state == PAYLOAD) && (state_nxt == DONE);

  always_ff @(posedge prog_clk) begin
    if (pReset || go) begin
      s   <= '0;
      err <= 1'b0;
      ok  <= 1'b0;
    end else begin
      if (ccff_shift_en) s <= s + SW'(1);
      if (chk_fail) err <= 1'b1;
      if (to_done) ok <= !(err || chk_fail);
    end
  end

endmodule

// File: doc/ccff_stream_loader.md
Name: ccff_stream_loader

Overview:
- Bitstream writer that drives the configuration-chain input (ccff_head) of a grid tile chain and observes its end (ccff_tail).
- Accepts configuration words over a valid/ready stream and serializes them MSB-first, one bit per enabled cycle.
- Emits ccff_shift_en, which gates the chain's prog_clk through an external clock gate; the chain advances only on cycles where it is high.
- Prepends a fixed 8-bit header and checks that it emerges at ccff_tail exactly CHAIN_LEN shifts later, which verifies chain length and continuity.

Parameters:
- CHAIN_LEN, 64, number of configuration flops in the chain; must be at least 1.
- WORD_W, 8, input word width.
- HDR, 8'hA5, header pattern, shifted MSB-first.

Ports:
- prog_clk  in  1  clock.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  begins a load; honoured only in IDLE.
- in_data  in  WORD_W  configuration word, MSB shifted first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- ccff_head  out  1  serial bit into the chain.
- ccff_shift_en  out  1  chain advances at the end of this cycle.
- ccff_tail  in  1  last chain flop output.
- busy  out  1  high in HEADER and PAYLOAD.
- done  out  1  one-cycle pulse at the end of a load.
- chain_ok  out  1  header check result; valid from the done cycle and held until the next start.

Behaviour:
- Clock and reset: single clock, prog_clk. pReset is synchronous and active-high.
- Reset values: all outputs 0. State is IDLE and all counters are cleared.
- States: IDLE -> HEADER -> PAYLOAD -> DONE -> IDLE.
- IDLE:
  - start=1 moves to HEADER next cycle and clears chain_ok.
- HEADER:
  - 8 cycles; shift_en=1 on every cycle.
  - ccff_head = HDR[7-h] for h=0..7.
- PAYLOAD:
  - Holding register shreg with bit count wcnt; words_left = ceil(CHAIN_LEN/WORD_W) at entry.
  - An accepted word loads shreg on the next edge with wcnt = min(WORD_W, bits remaining).
  - In the final word, excess LSBs are discarded.
  - in_ready = words_left>0 && (wcnt==0 || (wcnt==1 && shift_en)).
  - in_ready is also high during HEADER cycle h=7, so the first word is taken without a bubble.
- Shifting:
  - shift_en = (wcnt!=0) in PAYLOAD.
  - ccff_head = shreg MSB when shift_en=1, otherwise 0.
  - A stall (no word available) drops shift_en; all counters hold.
- Global shift index s counts only cycles with shift_en=1, s = 0..CHAIN_LEN+7.
- Tail check:
  - On a shift cycle with CHAIN_LEN <= s <= CHAIN_LEN+7, compare ccff_tail with HDR[7-(s-CHAIN_LEN)].
  - Any mismatch sets a sticky error flag.
  - The window may overlap HEADER when CHAIN_LEN < 8.
- Exit from PAYLOAD: after shift s = CHAIN_LEN+7, go to DONE.
- DONE:
  - done=1 for exactly one cycle; chain_ok = !error.
  - The chain then holds exactly the CHAIN_LEN payload bits; the header has fallen off the chain end.
- Latency with no stalls: start in cycle 0 gives shift_en on cycles 1..CHAIN_LEN+8 and done in cycle CHAIN_LEN+9.
- start while busy or in DONE: ignored.
- in_valid outside in_ready cycles: ignored, no accept.
- pReset mid-load: the state machine immediately returns to IDLE. Chain contents are then undefined, and no done pulse is issued.
- Counter widths: $clog2(CHAIN_LEN+9) for s; $clog2(WORD_W+1) for wcnt.

Decomposition:
- Shared package ccff_pkg holds:
  - state enum (IDLE, HEADER, PAYLOAD, DONE);
  - CCFF_HDR_W = 8;
  - default header constant.
- One sub-module, ccff_word_piso: parallel-in/serial-out holding register that owns wcnt, shreg and the load/shift interface.
- The top level owns the state machine, the s counter and the tail comparator.

Test Plan:
1. CHAIN_LEN=20, WORD_W=8, gated 20-bit chain model; start, then stream 0xDE, 0xAD, 0xB7 back-to-back -> chain = 20'hDEADB, shift_en high for cycles 1..28, done in cycle 29, chain_ok=1.
2. Same as 1, with in_valid deasserted for 3 cycles mid-word-2 -> shift_en low exactly on the stall cycles, same final chain, chain_ok=1, done delayed by 3 cycles.
3. Chain model of 21 flops while CHAIN_LEN=20 -> header arrives one shift late, chain_ok=0 at done.
4. ccff_tail stuck at 0 -> chain_ok=0.
5. pReset asserted during payload shift s=12 -> next cycle all outputs 0 and state IDLE; a fresh start then completes normally with chain_ok=1.
6. start pulsed during PAYLOAD, and in_valid held with no load running -> no restart, in_ready stays 0 in IDLE, and exactly one done pulse per accepted start.
